// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the multi-cycle shift controller: state encodings, shift modes
// and default widths.
package shift_seq_pkg;

  localparam int unsigned AMT_W_DEF = 4;
  // Fixed to match the 1-bit shifter datapath.
  localparam int unsigned DATA_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_LSL  = 2'b01;
  localparam logic [1:0] OP_LSR  = 2'b10;
  localparam logic [1:0] OP_ASR  = 2'b11;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result bundle between the instruction-sequencing FSM (master) and the shift
// sequencer (slave).
interface shift_sequencer_if
  import shift_seq_pkg::*;
#(
  parameter int unsigned AMT_W = AMT_W_DEF
) ();

  logic              start;
  logic [1:0]        op;
  logic [AMT_W-1:0]  amount;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] dout;
  logic              cout;
  logic              zero;

  modport master (
    output start, op, amount, din,
    input  busy, done, dout, cout, zero
  );

  modport slave (
    input  start, op, amount, din,
    output busy, done, dout, cout, zero
  );

endinterface

// File: rtl/shift_sequencer_shifter.sv
// Single-pass 16-bit shifter: pass, logical left, logical right or arithmetic right
// by one bit.
module shifter
  import shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic [1:0]        shift,
  output logic [DATA_W-1:0] sout
);

  always_comb begin
    sout = in;
    unique case (shift)
      OP_PASS: sout = in;
      OP_LSL:  sout = {in[DATA_W-2:0], 1'b0};
      OP_LSR:  sout = {1'b0, in[DATA_W-1:1]};
      OP_ASR:  sout = {in[DATA_W-1], in[DATA_W-1:1]};
      default: sout = in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift-by-N controller: recirculates the accumulator through one 1-bit
// shifter per clock, then pulses done with the result, last bit shifted out and zero flag.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned AMT_W = AMT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  shift_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, acc_shift;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              cout_q, cout_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              shift_out;

  shifter u_shifter (
    .in    (acc_q),
    .shift (op_q),
    .sout  (acc_shift)
  );

  always_comb begin
    shift_out = 1'b0;
    unique case (op_q)
      OP_LSL:         shift_out = acc_q[DATA_W-1];
      OP_LSR, OP_ASR: shift_out = acc_q[0];
      default:        shift_out = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = bus.din;
          op_d    = bus.op;
          cnt_d   = bus.amount;
          cout_d  = 1'b0;
          state_d = (bus.amount != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        acc_d  = acc_shift;
        cnt_d  = cnt_q - AMT_W'(1);
        cout_d = shift_out;
        if (cnt_q == AMT_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flags are registered copies of the next state so they line up with the state.
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_PASS;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = acc_q;
  assign bus.cout = cout_q;
  assign bus.zero = (acc_q == '0);

endmodule
